// File: rtl/vstream_frame_ctrl.sv
// Frame sequencer for a raster video source: arms the source, waits for its done
// strobe, inserts an inter-frame gap, counts pixels per frame and guards with a watchdog.
module vstream_frame_ctrl #(
    parameter int FCNT_W         = 16,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int EXP_PIXELS     = 921600,
    parameter int PIX_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [FCNT_W-1:0] num_frames,
    output logic              src_begin,
    input  logic              src_done,
    input  logic              src_valid,
    output logic              busy,
    output logic [FCNT_W-1:0] frames_done,
    output logic              frame_pulse,
    output logic [PIX_W-1:0]  last_pix_cnt,
    output logic              pix_err,
    output logic              timeout_err
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                arm_cnt_q, arm_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [FCNT_W-1:0]   num_frames_q, num_frames_d;
    logic [FCNT_W-1:0]   frames_done_q, frames_done_d;
    logic [PIX_W-1:0]    last_pix_cnt_q, last_pix_cnt_d;
    logic                frame_pulse_q, frame_pulse_d;
    logic                pix_err_q, pix_err_d;
    logic                timeout_err_q, timeout_err_d;
    logic                stop_pending_q, stop_pending_d;

    logic                start_ok;
    logic                done_hit;
    logic                wd_expired;
    logic                gap_last;
    logic                seq_done;
    logic                enter_arm;
    logic [PIX_W-1:0]    pix_next;

    function automatic logic [PIX_W-1:0] sat_inc(input logic [PIX_W-1:0] cnt, input logic inc);
        if (inc && (cnt != '1)) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

    assign start_ok   = (state_q == S_IDLE) && start && !stop;
    assign done_hit   = (state_q == S_RUN) && src_done;
    // A done strobe on the last watchdog cycle wins over the timeout.
    assign wd_expired = (state_q == S_RUN) && !src_done &&
                        (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign gap_last   = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));
    assign seq_done   = stop_pending_q ||
                        ((num_frames_q != '0) && (frames_done_q == num_frames_q));
    assign pix_next   = sat_inc(pix_cnt_q, src_valid);
    assign enter_arm  = (state_d == S_ARM) && (state_q != S_ARM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_ok) state_d = S_ARM;
            S_ARM:  if (arm_cnt_q) state_d = S_RUN;
            S_RUN: begin
                if (src_done) begin
                    state_d = S_GAP;
                end else if (wd_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (gap_last) begin
                    state_d = seq_done ? S_IDLE : S_ARM;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        arm_cnt_d      = (state_q == S_ARM);
        gap_cnt_d      = (state_q == S_GAP) ? gap_cnt_q + 1'b1 : '0;
        wd_cnt_d       = (state_q == S_RUN) ? wd_cnt_q + 1'b1 : '0;
        pix_cnt_d      = pix_cnt_q;
        num_frames_d   = num_frames_q;
        frames_done_d  = frames_done_q;
        last_pix_cnt_d = last_pix_cnt_q;
        frame_pulse_d  = done_hit;
        pix_err_d      = pix_err_q;
        timeout_err_d  = timeout_err_q;
        stop_pending_d = stop_pending_q;

        // Valids during ARM belong to the upcoming frame.
        if (enter_arm) begin
            pix_cnt_d = '0;
        end else if ((state_q == S_ARM) || (state_q == S_RUN)) begin
            pix_cnt_d = pix_next;
        end

        if (start_ok) begin
            num_frames_d   = num_frames;
            frames_done_d  = '0;
            last_pix_cnt_d = '0;
            pix_err_d      = 1'b0;
            timeout_err_d  = 1'b0;
            stop_pending_d = 1'b0;
        end

        if (stop && ((state_q == S_ARM) || (state_q == S_RUN))) begin
            stop_pending_d = 1'b1;
        end

        if (done_hit) begin
            last_pix_cnt_d = pix_next;
            frames_done_d  = frames_done_q + 1'b1;
            if (pix_next != PIX_W'(EXP_PIXELS)) begin
                pix_err_d = 1'b1;
            end
        end

        if (wd_expired) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arm_cnt_q      <= 1'b0;
            gap_cnt_q      <= '0;
            wd_cnt_q       <= '0;
            pix_cnt_q      <= '0;
            num_frames_q   <= '0;
            frames_done_q  <= '0;
            last_pix_cnt_q <= '0;
            frame_pulse_q  <= 1'b0;
            pix_err_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
            stop_pending_q <= 1'b0;
        end else begin
            arm_cnt_q      <= arm_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            wd_cnt_q       <= wd_cnt_d;
            pix_cnt_q      <= pix_cnt_d;
            num_frames_q   <= num_frames_d;
            frames_done_q  <= frames_done_d;
            last_pix_cnt_q <= last_pix_cnt_d;
            frame_pulse_q  <= frame_pulse_d;
            pix_err_q      <= pix_err_d;
            timeout_err_q  <= timeout_err_d;
            stop_pending_q <= stop_pending_d;
        end
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        src_begin    = (state_q == S_ARM);
        frames_done  = frames_done_q;
        frame_pulse  = frame_pulse_q;
        last_pix_cnt = last_pix_cnt_q;
        pix_err      = pix_err_q;
        timeout_err  = timeout_err_q;
    end

endmodule

// File: tb/tb_vstream_frame_ctrl.sv
// Randomized bench for vstream_frame_ctrl: a reactive 4x4 source with random blanking,
// checked against a frame-level expectation model (frame counts, pixel totals, gap lengths).
module tb_vstream_frame_ctrl;

    localparam int FCNT_W = 16;
    localparam int PIX_W  = 32;
    localparam int GAP    = 4;
    localparam int TMO    = 200;
    localparam int EXP    = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [FCNT_W-1:0] num_frames = '0;
    logic              src_begin;
    logic              src_done = 1'b0;
    logic              src_valid = 1'b0;
    logic              busy;
    logic [FCNT_W-1:0] frames_done;
    logic              frame_pulse;
    logic [PIX_W-1:0]  last_pix_cnt;
    logic              pix_err;
    logic              timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    // Frame-level reference model
    int exp_fd;
    int exp_last;
    bit exp_pe;

    vstream_frame_ctrl #(
        .FCNT_W(FCNT_W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO),
        .EXP_PIXELS(EXP), .PIX_W(PIX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .num_frames(num_frames),
        .src_begin(src_begin), .src_done(src_done), .src_valid(src_valid), .busy(busy),
        .frames_done(frames_done), .frame_pulse(frame_pulse), .last_pix_cnt(last_pix_cnt),
        .pix_err(pix_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (frame_pulse) pulses++;
    endtask

    // Runs one start..idle sequence. stop_frame: frame in which stop is issued (0 = none);
    // stop_gap selects a stop during the gap after that frame instead of mid-frame.
    task automatic run_seq(input int nf, input int stop_frame, input bit stop_gap,
                           input int bad_frame, input int bad_cnt);
        int  f, arm_v, cnt, remaining, k, pulses0;
        bit  stop_sent, finished, dlast;
        num_frames = FCNT_W'(nf);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_begin", src_begin, 1);
        chk("start_busy", busy, 1);
        chk("start_fd_clr", frames_done, 0);
        chk("start_pixerr_clr", pix_err, 0);
        chk("start_tmo_clr", timeout_err, 0);
        chk("start_last_clr", last_pix_cnt, 0);
        exp_fd = 0; exp_last = 0; exp_pe = 1'b0;
        pulses0 = pulses; stop_sent = 1'b0; finished = 1'b0; f = 0;
        while (!finished) begin
            f++;
            arm_v = 0; k = 0;
            while (src_begin && k < 10) begin
                src_valid = 1'($urandom_range(0, 1));
                if (src_valid) arm_v++;
                cyc();
                k++;
            end
            src_valid = 1'b0;
            chk("arm_len", k, 2);
            cnt = (f == bad_frame) ? bad_cnt : EXP;
            remaining = cnt - arm_v;
            dlast = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) cyc();
            for (int i = 0; i < remaining; i++) begin
                repeat ($urandom_range(0, 2)) cyc();
                src_valid = 1'b1;
                if (i == remaining / 2 && f == stop_frame && !stop_gap) begin
                    stop = 1'b1;
                    stop_sent = 1'b1;
                end
                if (i == 3) begin
                    start = 1'($urandom_range(0, 1));
                    num_frames = FCNT_W'($urandom);
                end
                if (i == remaining - 1 && dlast) src_done = 1'b1;
                cyc();
                src_valid = 1'b0; stop = 1'b0; start = 1'b0; src_done = 1'b0;
            end
            if (!dlast) begin
                repeat ($urandom_range(0, 2)) cyc();
                src_done = 1'b1;
                cyc();
                src_done = 1'b0;
            end
            exp_fd++;
            exp_last = cnt;
            if (cnt != EXP) exp_pe = 1'b1;
            chk("frame_pulse", frame_pulse, 1);
            chk("frames_done", frames_done, exp_fd);
            chk("last_pix_cnt", last_pix_cnt, exp_last);
            chk("pix_err", pix_err, exp_pe);
            chk("busy_in_gap", busy, 1);
            if (stop_gap && f == stop_frame) begin
                stop = 1'b1;
                cyc();
                stop = 1'b0;
                chk("gap_stop_idle", busy, 0);
                finished = 1'b1;
            end else begin
                k = 0;
                while (!src_begin && busy && k < 50) begin
                    cyc();
                    k++;
                end
                chk("gap_len", k, GAP);
                if (stop_sent || (nf != 0 && exp_fd == nf)) begin
                    chk("seq_end_idle", busy, 0);
                    finished = 1'b1;
                end else begin
                    chk("next_arm", src_begin, 1);
                end
                if (f >= 20) finished = 1'b1;
            end
        end
        repeat (3) cyc();
        chk("no_restart_busy", busy, 0);
        chk("no_restart_begin", src_begin, 0);
        chk("pulse_count", pulses - pulses0, exp_fd);
        chk("final_frames_done", frames_done, exp_fd);
    endtask

    task automatic timeout_run(input bit done_last);
        int k;
        num_frames = FCNT_W'(1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        k = 0;
        while (src_begin && k < 10) begin
            cyc();
            k++;
        end
        k = 0;
        while (busy && k < 1000) begin
            src_valid = (k < EXP);
            src_done  = done_last && (k == TMO - 1);
            cyc();
            k++;
            if (src_done) begin
                src_done = 1'b0;
                break;
            end
        end
        src_valid = 1'b0;
        src_done  = 1'b0;
        if (done_last) begin
            chk("edge_done_pulse", frame_pulse, 1);
            chk("edge_done_tmo", timeout_err, 0);
            chk("edge_done_fd", frames_done, 1);
            chk("edge_done_last", last_pix_cnt, EXP);
            k = 0;
            while (busy && k < 50) begin
                cyc();
                k++;
            end
            chk("edge_done_idle", busy, 0);
        end else begin
            chk("tmo_cycles", k, TMO);
            chk("tmo_err", timeout_err, 1);
            chk("tmo_fd", frames_done, 0);
            chk("tmo_busy", busy, 0);
            repeat (3) cyc();
            chk("tmo_sticky", timeout_err, 1);
        end
    endtask

    task automatic reset_mid_run();
        int k;
        num_frames = '0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        k = 0;
        while (src_begin && k < 10) begin
            cyc();
            k++;
        end
        for (int i = 0; i < EXP - 1; i++) begin
            src_valid = 1'b1;
            src_done  = (i == EXP - 2);
            cyc();
        end
        src_valid = 1'b0;
        src_done  = 1'b0;
        chk("rst_pre_pixerr", pix_err, 1);
        chk("rst_pre_last", last_pix_cnt, EXP - 1);
        k = 0;
        while (!src_begin && k < 50) begin
            cyc();
            k++;
        end
        while (src_begin && k < 60) begin
            cyc();
            k++;
        end
        repeat (3) begin
            src_valid = 1'b1;
            cyc();
        end
        src_valid = 1'b0;
        chk("rst_pre_busy", busy, 1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_begin", src_begin, 0);
        chk("rst_fd", frames_done, 0);
        chk("rst_last", last_pix_cnt, 0);
        chk("rst_pixerr", pix_err, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_pulse", frame_pulse, 0);
        repeat (3) cyc();
        chk("rst_stays_idle", busy, 0);
    endtask

    initial begin
        int nf, bad, badcnt, stopf;
        rst_n = 1'b0;
        repeat (3) cyc();
        chk("reset_busy", busy, 0);
        chk("reset_begin", src_begin, 0);
        chk("reset_fd", frames_done, 0);
        chk("reset_last", last_pix_cnt, 0);
        chk("reset_pixerr", pix_err, 0);
        chk("reset_tmo", timeout_err, 0);
        chk("reset_pulse", frame_pulse, 0);
        rst_n = 1'b1;
        cyc();

        run_seq(3, 0, 1'b0, 0, EXP);
        run_seq(0, 5, 1'b0, 0, EXP);
        run_seq(3, 0, 1'b0, 2, EXP - 1);
        timeout_run(1'b0);
        run_seq(1, 0, 1'b0, 0, EXP);
        timeout_run(1'b1);

        start = 1'b1; stop = 1'b1; src_done = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0; src_done = 1'b0;
        chk("start_stop_idle", busy, 0);
        chk("idle_done_ignored", frame_pulse, 0);
        cyc();
        chk("start_stop_still_idle", busy, 0);

        run_seq(0, 2, 1'b1, 0, EXP);
        reset_mid_run();

        repeat (6) begin
            nf     = int'($urandom_range(1, 4));
            bad    = int'($urandom_range(0, nf));
            badcnt = ($urandom_range(0, 1) == 0) ? EXP - 1 : EXP + 1;
            stopf  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, nf)) : 0;
            run_seq(nf, stopf, 1'b0, bad, badcnt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
